team_gpio_scheduler: RTL and testbench
======================================

# team_gpio_scheduler

Shares the user-project GPIO pads (mprj_io[37:5] and mprj_io[0], 34 pins) between team designs inside the user project wrapper. The block holds a selection register written through a valid/ready request port. It grants exactly one team enable and muxes that team's pad outputs and output-enables onto the pads. On every hand-over it parks all pads at high-Z for a guard interval, so the outgoing and incoming designs never drive the pads in the same cycle.

## Interface
Parameters:
- NUM_TEAMS, 4: number of team designs sharing the pads.
- NUM_PINS, 34: pads under control.
- GUARD_CYCLES, 8: high-Z cycles on each hand-over, 1..255.
- SEL_W, $clog2(NUM_TEAMS+1): selection width; value 0 = parked.

Ports:
- wb_clk_i  in  1  system clock, 40 MHz.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- req_valid  in  1  switch request.
- req_sel  in  SEL_W  target team, 1..NUM_TEAMS; 0 = park.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- team_io_out  in  NUM_TEAMS*NUM_PINS  team pad outputs; team k occupies slice [k*NUM_PINS +: NUM_PINS], k = sel-1.
- team_io_oeb  in  NUM_TEAMS*NUM_PINS  team output-enables, active-low, same slicing.
- io_out  out  NUM_PINS  pad outputs.
- io_oeb  out  NUM_PINS  pad output-enables, active-low.
- team_en  out  NUM_TEAMS  one-hot or zero team enable.
- active_sel  out  SEL_W  currently granted selection.
- busy  out  1  hand-over in progress.

## Operation
- Three states: PARK, GUARD, ACTIVE.
- PARK: team_en=0, active_sel=0, io_out=0, io_oeb=all 1.
- ACTIVE: team_en[active_sel-1]=1. io_out/io_oeb are the registered slice of the granted team.
- GUARD: team_en=0, io_out=0, io_oeb=all 1, busy=1. A down-counter is loaded with GUARD_CYCLES.
- req_ready=1 in PARK and ACTIVE, 0 in GUARD. A request is accepted on valid && ready.
- Request with req_sel > NUM_TEAMS: accepted and treated as 0.
- Request equal to active_sel: accepted, no state change, no guard, no output glitch.
- Any other accepted request: the target is latched and the state moves to GUARD.
- When the GUARD counter reaches 1: go to PARK if the target is 0, otherwise go to ACTIVE with active_sel=target.
- req_sel is ignored while req_valid is low.

## Timing
- Reset values: state PARK, team_en=0, active_sel=0, io_out=0, io_oeb=all 1, busy=0, req_ready=1, counter 0.
- Reset asserted mid-GUARD or mid-ACTIVE: outputs take their reset values immediately (asynchronously). A pending target is discarded.
- Request accepted at edge T:
  - From edge T, team_en=0, io_oeb=all 1, busy=1, req_ready=0.
  - The guard lasts exactly GUARD_CYCLES cycles.
  - At edge T+GUARD_CYCLES: busy=0, req_ready=1, active_sel=target, team_en asserted.
  - The first team-driven io_out/io_oeb appear at edge T+GUARD_CYCLES+1 (one-cycle output register).
- In ACTIVE, pad latency is 1 cycle from team_io_* to io_*.
- Back-to-back requests: a request held through GUARD is accepted at the first ready cycle after the guard.
- Every output is registered; no combinational path from team_io_* to io_*.

## Structure
- Package team_gpio_sched_pkg holds:
  - state enum (PARK, GUARD, ACTIVE);
  - SEL_PARK = 0;
  - pad-safe constants PAD_OUT_SAFE = 0 and PAD_OEB_SAFE = all 1.
- One sub-module, gpio_guard_timer: loadable 8-bit down-counter with a `done` pulse. The mux and FSM stay in the top module.

## Test plan
- Reset, no requests: io_oeb=34'h3_FFFF_FFFF, io_out=0, team_en=0, req_ready=1. Assert wb_rst_i mid-GUARD: same values immediately.
- From PARK, request sel=2 (GUARD_CYCLES=8), with team 2 driving out=34'h2_AAAA_5555 and oeb=0:
  - busy for 8 cycles, then team_en=4'b0010;
  - io_out=34'h2_AAAA_5555 and io_oeb=0 one cycle later.
- ACTIVE sel=2, request sel=3:
  - team_en goes to 0 at the accept edge;
  - pads stay high-Z for exactly 8 cycles with no cycle where both team_en bits are set;
  - then team 3's slice appears.
- ACTIVE sel=1, request sel=1: accepted, busy stays 0, io_out unchanged every cycle.
- Request sel=7 with NUM_TEAMS=4: accepted, guard of 8 cycles, ends in PARK with active_sel=0.
- Hold req_valid high with sel=4 during a guard: req_ready=0 throughout. sel=4 is accepted on the first cycle after the guard, starting a second 8-cycle guard.

Source files
------------

// File: rtl/team_gpio_sched_pkg.sv
// rtl/team_gpio_sched_pkg.sv - shared types and pad-safe constants for the GPIO scheduler
package team_gpio_sched_pkg;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        GUARD  = 2'd1,
        ACTIVE = 2'd2
    } sched_state_e;

    localparam int SEL_PARK = 0;

    // Per-bit safe pad values, replicated to the pad width by users.
    localparam logic PAD_OUT_SAFE = 1'b0;
    localparam logic PAD_OEB_SAFE = 1'b1;

endpackage

// File: rtl/gpio_guard_timer.sv
// rtl/gpio_guard_timer.sv - loadable 8-bit down-counter, done while the count is 1
module gpio_guard_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count parks at 0 after expiring, so done is a single-cycle pulse.
    assign done = (count_q == 8'd1);

endmodule

// File: rtl/team_gpio_scheduler.sv
// rtl/team_gpio_scheduler.sv - grants the shared user-project pads to one team with a high-Z hand-over guard
module team_gpio_scheduler
    import team_gpio_sched_pkg::*;
#(
    parameter int NUM_TEAMS    = 4,
    parameter int NUM_PINS     = 34,
    parameter int GUARD_CYCLES = 8,
    parameter int SEL_W        = $clog2(NUM_TEAMS + 1)
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          req_valid,
    input  logic [SEL_W-1:0]              req_sel,
    output logic                          req_ready,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] team_io_out,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] team_io_oeb,
    output logic [NUM_PINS-1:0]           io_out,
    output logic [NUM_PINS-1:0]           io_oeb,
    output logic [NUM_TEAMS-1:0]          team_en,
    output logic [SEL_W-1:0]              active_sel,
    output logic                          busy
);

    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_TEAMS);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(SEL_PARK);

    sched_state_e        state_q, state_d;
    logic [SEL_W-1:0]    active_sel_q, active_sel_d;
    logic [SEL_W-1:0]    target_q, target_d;
    logic [NUM_PINS-1:0] io_out_q, io_out_d;
    logic [NUM_PINS-1:0] io_oeb_q, io_oeb_d;

    logic [SEL_W-1:0] eff_sel;
    logic             ready;
    logic             accept;
    logic             switch_req;
    logic             guard_done;

    // Out-of-range selections behave exactly like a park request.
    assign eff_sel    = (req_sel > SEL_MAX) ? SEL_NONE : req_sel;
    assign ready      = (state_q != GUARD);
    assign accept     = req_valid && ready;
    assign switch_req = accept && (eff_sel != active_sel_q);

    gpio_guard_timer u_guard_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (switch_req),
        .load_val (8'(GUARD_CYCLES)),
        .done     (guard_done)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= PARK;
            active_sel_q <= SEL_NONE;
            target_q     <= SEL_NONE;
            io_out_q     <= {NUM_PINS{PAD_OUT_SAFE}};
            io_oeb_q     <= {NUM_PINS{PAD_OEB_SAFE}};
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            target_q     <= target_d;
            io_out_q     <= io_out_d;
            io_oeb_q     <= io_oeb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        target_d     = target_q;
        case (state_q)
            PARK, ACTIVE: begin
                if (switch_req) begin
                    state_d      = GUARD;
                    target_d     = eff_sel;
                    active_sel_d = SEL_NONE;
                end
            end
            GUARD: begin
                if (guard_done) begin
                    active_sel_d = target_q;
                    state_d      = (target_q == SEL_NONE) ? PARK : ACTIVE;
                end
            end
            default: begin
                state_d      = PARK;
                active_sel_d = SEL_NONE;
            end
        endcase
    end

    // Pads follow a team only while it stays granted across the edge, so a leaving team is cut at the accept edge.
    always_comb begin
        io_out_d = {NUM_PINS{PAD_OUT_SAFE}};
        io_oeb_d = {NUM_PINS{PAD_OEB_SAFE}};
        if ((state_q == ACTIVE) && (state_d == ACTIVE)) begin
            for (int k = 0; k < NUM_TEAMS; k++) begin
                if (active_sel_q == SEL_W'(k + 1)) begin
                    io_out_d = team_io_out[k*NUM_PINS +: NUM_PINS];
                    io_oeb_d = team_io_oeb[k*NUM_PINS +: NUM_PINS];
                end
            end
        end
    end

    always_comb begin
        team_en = '0;
        for (int k = 0; k < NUM_TEAMS; k++) begin
            team_en[k] = (state_q == ACTIVE) && (active_sel_q == SEL_W'(k + 1));
        end
        busy       = (state_q == GUARD);
        req_ready  = ready;
        active_sel = active_sel_q;
        io_out     = io_out_q;
        io_oeb     = io_oeb_q;
    end

endmodule

// File: tb/tb_team_gpio_scheduler.sv
// tb/tb_team_gpio_scheduler.sv - self-checking bench for team_gpio_scheduler
module tb_team_gpio_scheduler;

    localparam int NT = 4;
    localparam int NP = 34;
    localparam int G  = 8;
    localparam int SW = 3;
    localparam logic [NP-1:0] SAFE_OUT = 34'h0;
    localparam logic [NP-1:0] SAFE_OEB = 34'h3_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [SW-1:0]      req_sel;
    logic               req_ready;
    logic [NT*NP-1:0]   team_io_out;
    logic [NT*NP-1:0]   team_io_oeb;
    logic [NP-1:0]      io_out;
    logic [NP-1:0]      io_oeb;
    logic [NT-1:0]      team_en;
    logic [SW-1:0]      active_sel;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: granted team, remaining guard cycles, pending target, expected pads.
    int            m_sel;
    int            m_guard;
    int            m_target;
    logic [NP-1:0] m_out;
    logic [NP-1:0] m_oeb;

    typedef struct {
        logic          v;
        logic [SW-1:0] sel;
        logic          busy;
        logic          rdy;
        logic [SW-1:0] as;
        logic [NT-1:0] en;
        logic [NP-1:0] out;
        logic [NP-1:0] oeb;
    } vec_t;

    vec_t tbl[$];

    team_gpio_scheduler #(
        .NUM_TEAMS    (NT),
        .NUM_PINS     (NP),
        .GUARD_CYCLES (G),
        .SEL_W        (SW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .team_io_out (team_io_out),
        .team_io_oeb (team_io_oeb),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .team_en     (team_en),
        .active_sel  (active_sel),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input int sel, input logic b, input logic r,
                                input int as, input logic [NT-1:0] en,
                                input logic [NP-1:0] o, input logic [NP-1:0] e);
        vec_t x;
        x.v = v; x.sel = SW'(sel); x.busy = b; x.rdy = r; x.as = SW'(as);
        x.en = en; x.out = o; x.oeb = e;
        return x;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_guard = 0; m_target = 0;
        m_out = SAFE_OUT; m_oeb = SAFE_OEB;
    endtask

    task automatic check_model();
        logic [NT-1:0] exp_en;
        exp_en = '0;
        if (m_guard == 0 && m_sel != 0) exp_en[m_sel-1] = 1'b1;
        check("model team_en", 64'(team_en), 64'(exp_en));
        check("model active_sel", 64'(active_sel), 64'(m_sel));
        check("model busy", 64'(busy), 64'(m_guard > 0));
        check("model req_ready", 64'(req_ready), 64'(m_guard == 0));
        check("model io_out", 64'(io_out), 64'(m_out));
        check("model io_oeb", 64'(io_oeb), 64'(m_oeb));
    endtask

    // One clock: derive the next model state from pre-edge inputs, then compare after the edge.
    task automatic cycle();
        int ns, ng, nt, eff;
        logic [NP-1:0] no, nb;
        ns = m_sel; ng = m_guard; nt = m_target;
        if (m_guard > 0) begin
            ng = m_guard - 1;
            if (ng == 0) ns = m_target;
        end else if (req_valid) begin
            eff = (int'(req_sel) > NT) ? 0 : int'(req_sel);
            if (eff != m_sel) begin
                ng = G; nt = eff; ns = 0;
            end
        end
        if (m_sel != 0 && m_guard == 0 && ng == 0) begin
            no = team_io_out[(m_sel-1)*NP +: NP];
            nb = team_io_oeb[(m_sel-1)*NP +: NP];
        end else begin
            no = SAFE_OUT; nb = SAFE_OEB;
        end
        @(posedge clk);
        #1;
        m_sel = ns; m_guard = ng; m_target = nt; m_out = no; m_oeb = nb;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " team_en"}, 64'(team_en), 64'h0);
        check({tag, " active_sel"}, 64'(active_sel), 64'h0);
        check({tag, " io_out"}, 64'(io_out), 64'h0);
        check({tag, " io_oeb"}, 64'(io_oeb), 64'h3_FFFF_FFFF);
        check({tag, " busy"}, 64'(busy), 64'h0);
        check({tag, " req_ready"}, 64'(req_ready), 64'h1);
    endtask

    initial begin
        logic [NP-1:0] prev;
        int cnt;

        rst = 1'b1; req_valid = 1'b0; req_sel = '0;
        team_io_out[0*NP +: NP] = 34'h0_1111_1111; team_io_oeb[0*NP +: NP] = 34'h0_0000_FFFF;
        team_io_out[1*NP +: NP] = 34'h2_AAAA_5555; team_io_oeb[1*NP +: NP] = 34'h0;
        team_io_out[2*NP +: NP] = 34'h1_2345_6789; team_io_oeb[2*NP +: NP] = 34'h0_F0F0_F0F0;
        team_io_out[3*NP +: NP] = 34'h3_CCCC_3333; team_io_oeb[3*NP +: NP] = 34'h1_0000_0001;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // PARK -> team 2, then team 2 -> team 3.
        tbl.push_back(mk(1, 2, 1, 0, 0, 4'b0000, SAFE_OUT, SAFE_OEB));
        for (int i = 0; i < G-1; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 4'b0000, SAFE_OUT, SAFE_OEB));
        tbl.push_back(mk(0, 0, 0, 1, 2, 4'b0010, SAFE_OUT, SAFE_OEB));
        tbl.push_back(mk(0, 0, 0, 1, 2, 4'b0010, 34'h2_AAAA_5555, 34'h0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 4'b0000, SAFE_OUT, SAFE_OEB));
        for (int i = 0; i < G-1; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 4'b0000, SAFE_OUT, SAFE_OEB));
        tbl.push_back(mk(0, 0, 0, 1, 3, 4'b0100, SAFE_OUT, SAFE_OEB));
        tbl.push_back(mk(0, 0, 0, 1, 3, 4'b0100, 34'h1_2345_6789, 34'h0_F0F0_F0F0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v;
            req_sel   = tbl[i].sel;
            cycle();
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].busy));
            check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
            check($sformatf("vec%0d active_sel", i), 64'(active_sel), 64'(tbl[i].as));
            check($sformatf("vec%0d team_en", i), 64'(team_en), 64'(tbl[i].en));
            check($sformatf("vec%0d io_out", i), 64'(io_out), 64'(tbl[i].out));
            check($sformatf("vec%0d io_oeb", i), 64'(io_oeb), 64'(tbl[i].oeb));
        end

        // Hand over to team 1, then repeat requests for team 1 while its data moves.
        req_valid = 1'b1; req_sel = 3'd1;
        cycle();
        req_valid = 1'b0;
        repeat (G + 1) cycle();
        check("to team1 active_sel", 64'(active_sel), 64'd1);
        req_valid = 1'b1; req_sel = 3'd1;
        for (int i = 0; i < 6; i++) begin
            prev = {$urandom, $urandom};
            team_io_out[0*NP +: NP] = prev;
            cycle();
            check("same-sel busy", 64'(busy), 64'h0);
            check("same-sel io_out", 64'(io_out), 64'(prev));
        end

        // Out-of-range selection parks after a full guard.
        req_valid = 1'b1; req_sel = 3'd7;
        cycle();
        req_valid = 1'b0;
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (busy) cnt++;
        end
        check("sel7 guard length", 64'(cnt), 64'd8);
        check("sel7 active_sel", 64'(active_sel), 64'd0);
        check("sel7 team_en", 64'(team_en), 64'd0);
        check("sel7 io_oeb", 64'(io_oeb), 64'(SAFE_OEB));

        // Request held through a guard is taken on the first ready cycle.
        req_valid = 1'b1; req_sel = 3'd2;
        cycle();
        req_sel = 3'd4;
        for (int i = 0; i < G-1; i++) begin
            cycle();
            check("held req_ready low", 64'(req_ready), 64'h0);
        end
        cycle();
        check("held first ready", 64'(req_ready), 64'h1);
        check("held first grant", 64'(active_sel), 64'd2);
        cycle();
        check("held second guard", 64'(busy), 64'h1);
        req_valid = 1'b0;
        repeat (G) cycle();
        check("held final sel", 64'(active_sel), 64'd4);
        check("held final en", 64'(team_en), 64'b1000);

        // Asynchronous reset in the middle of a guard.
        req_valid = 1'b1; req_sel = 3'd1;
        cycle();
        req_valid = 1'b0;
        repeat (3) cycle();
        #3 rst = 1'b1;
        #1;
        check_reset_values("async reset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        check_model();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 99) < 30);
            req_sel   = SW'($urandom_range(0, 7));
            for (int k = 0; k < NT; k++) begin
                team_io_out[k*NP +: NP] = {$urandom, $urandom};
                team_io_oeb[k*NP +: NP] = {$urandom, $urandom};
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
